// File: rtl/craft_add_round_constant.sv
// rtl/craft_add_round_constant.sv - nibble-serial CRAFT AddRoundConstant stage
module craft_add_round_constant (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       en,
  input  logic [3:0] in,
  output logic [3:0] out,
  output logic       out_valid,
  output logic [4:0] round_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] nib_cnt_q, nib_cnt_d;
  logic [4:0] round_q, round_d;
  logic [3:0] a_q, a_d;
  logic [2:0] b_q, b_d;
  logic [3:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;
  logic       done_q, done_d;

  logic       accept;
  logic [3:0] rc_nib;

  // Only nibbles 4 and 5 of every round carry a round constant.
  always_comb begin
    rc_nib = 4'h0;
    if (nib_cnt_q == 4'd4) begin
      rc_nib = a_q;
    end else if (nib_cnt_q == 4'd5) begin
      rc_nib = {1'b0, b_q};
    end
  end

  // start wins over en, so a nibble arriving with start is dropped.
  assign accept = (state_q == ST_RUN) & en & ~start;

  // Next-state logic: restart, accept a nibble, step LFSRs at end of round.
  always_comb begin
    state_d     = state_q;
    nib_cnt_d   = nib_cnt_q;
    round_d     = round_q;
    a_d         = a_q;
    b_d         = b_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;

    if (start) begin
      state_d   = ST_RUN;
      nib_cnt_d = 4'd0;
      round_d   = 5'd0;
      a_d       = 4'h1;
      b_d       = 3'h1;
    end else if (accept) begin
      out_d       = in ^ rc_nib;
      out_valid_d = 1'b1;
      nib_cnt_d   = nib_cnt_q + 4'd1;
      if (nib_cnt_q == 4'd15) begin
        a_d     = {a_q[0] ^ a_q[1], a_q[3:1]};
        b_d     = {b_q[0] ^ b_q[2], b_q[2:1]};
        round_d = round_q + 5'd1;
        if (round_q == 5'd31) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  // State register; reset abandons any in-flight round immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      nib_cnt_q   <= 4'd0;
      round_q     <= 5'd0;
      a_q         <= 4'h1;
      b_q         <= 3'h1;
      out_q       <= 4'h0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nib_cnt_q   <= nib_cnt_d;
      round_q     <= round_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign round_idx = round_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_craft_add_round_constant.sv
// tb/tb_craft_add_round_constant.sv - self-checking bench for craft_add_round_constant
module tb_craft_add_round_constant;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       en;
  logic [3:0] in;
  logic [3:0] out;
  logic       out_valid;
  logic [4:0] round_idx;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  typedef struct {
    logic [3:0] in_nib;
    logic [3:0] exp_out;
    logic       exp_valid;
  } vec_t;

  vec_t       vecs[16];
  logic [3:0] a_seq[15];
  logic [2:0] b_seq[7];

  craft_add_round_constant dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .en        (en),
    .in        (in),
    .out       (out),
    .out_valid (out_valid),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] rc(input int r, input int n);
    if (n == 4) return a_seq[r % 15];
    if (n == 5) return {1'b0, b_seq[r % 7]};
    return 4'h0;
  endfunction

  task automatic step(input logic e, input logic [3:0] nib);
    en = e;
    in = nib;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    en    = 1'b0;
    in    = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    en    = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int done_cnt;
    int idx;
    int cyc;
    logic [3:0] last_out;
    logic e;

    checks = 0;
    errors = 0;
    a_seq = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB,
              4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3};
    b_seq = '{3'h1, 3'h4, 3'h6, 3'h7, 3'h3, 3'h5, 3'h2};
    for (int i = 0; i < 16; i++) begin
      vecs[i].in_nib    = 4'h0;
      vecs[i].exp_out   = (i == 4 || i == 5) ? 4'h1 : 4'h0;
      vecs[i].exp_valid = 1'b1;
    end

    // Reset state
    do_reset();
    check("rst_out", {4'h0, out}, 8'h00);
    check("rst_valid", {7'h0, out_valid}, 8'h00);
    check("rst_busy", {7'h0, busy}, 8'h00);
    check("rst_done", {7'h0, done}, 8'h00);
    check("rst_round", {3'h0, round_idx}, 8'h00);

    // en while idle before start
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'h5);
      check("idle_pre_valid", {7'h0, out_valid}, 8'h00);
      check("idle_pre_out", {4'h0, out}, 8'h00);
    end

    // Round 0 with zero nibbles, table driven
    pulse_start();
    check("start_busy", {7'h0, busy}, 8'h01);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, vecs[i].in_nib);
      check($sformatf("r0_out[%0d]", i), {4'h0, out}, {4'h0, vecs[i].exp_out});
      check($sformatf("r0_valid[%0d]", i), {7'h0, out_valid}, {7'h0, vecs[i].exp_valid});
    end
    check("r0_round_after", {3'h0, round_idx}, 8'h01);

    // Full 512-nibble run of 0xF
    do_reset();
    pulse_start();
    done_cnt = 0;
    for (int r = 0; r < 32; r++) begin
      for (int n = 0; n < 16; n++) begin
        check("full_round", {3'h0, round_idx}, r[7:0]);
        step(1'b1, 4'hF);
        check($sformatf("full_out[r%0d n%0d]", r, n), {4'h0, out}, {4'h0, 4'hF ^ rc(r, n)});
        if (done) done_cnt++;
        if (r == 3 && n == 4) check("r3_n4", {4'h0, out}, 8'h0D);
        if (r == 3 && n == 5) check("r3_n5", {4'h0, out}, 8'h08);
        if (r == 31 && n == 4) check("r31_n4", {4'h0, out}, 8'h07);
        if (r == 31 && n == 5) check("r31_n5", {4'h0, out}, 8'h08);
      end
    end
    check("full_done_final", {7'h0, done}, 8'h01);
    check("full_valid_final", {7'h0, out_valid}, 8'h01);
    check("full_busy_final", {7'h0, busy}, 8'h00);
    check("full_round_wrap", {3'h0, round_idx}, 8'h00);
    last_out = out;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'h3);
      if (done) done_cnt++;
      check("idle_post_valid", {7'h0, out_valid}, 8'h00);
      check("idle_post_out", {4'h0, out}, {4'h0, last_out});
      check("idle_post_busy", {7'h0, busy}, 8'h00);
    end
    check("done_pulses", done_cnt[7:0], 8'h01);

    // Random stalls in round 0, in = nibble index
    do_reset();
    pulse_start();
    idx = 0;
    cyc = 0;
    last_out = out;
    while (idx < 16 && cyc < 300) begin
      e = 1'($urandom_range(0, 1));
      step(e, idx[3:0]);
      cyc++;
      if (e) begin
        check("stall_valid", {7'h0, out_valid}, 8'h01);
        check($sformatf("stall_out[%0d]", idx), {4'h0, out}, {4'h0, idx[3:0] ^ rc(0, idx)});
        last_out = out;
        idx++;
      end else begin
        check("stall_gap_valid", {7'h0, out_valid}, 8'h00);
        check("stall_gap_out", {4'h0, out}, {4'h0, last_out});
      end
    end
    check("stall_finished", {7'h0, 1'(idx == 16)}, 8'h01);
    check("stall_round_after", {3'h0, round_idx}, 8'h01);

    // start mid-round 5 with en in the same cycle
    do_reset();
    pulse_start();
    for (int i = 0; i < 5 * 16 + 7; i++) step(1'b1, 4'hA);
    check("mid_r5_round", {3'h0, round_idx}, 8'h05);
    start = 1'b1;
    step(1'b1, 4'h9);
    start = 1'b0;
    check("restart_drop_valid", {7'h0, out_valid}, 8'h00);
    check("restart_round", {3'h0, round_idx}, 8'h00);
    check("restart_busy", {7'h0, busy}, 8'h01);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, vecs[i].in_nib);
      check($sformatf("restart_out[%0d]", i), {4'h0, out}, {4'h0, vecs[i].exp_out});
    end

    // Asynchronous reset between edges during round 2
    do_reset();
    pulse_start();
    for (int i = 0; i < 2 * 16 + 3; i++) step(1'b1, 4'hF);
    check("pre_arst_valid", {7'h0, out_valid}, 8'h01);
    check("pre_arst_out", {4'h0, out}, 8'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", {4'h0, out}, 8'h00);
    check("arst_valid", {7'h0, out_valid}, 8'h00);
    check("arst_busy", {7'h0, busy}, 8'h00);
    check("arst_done", {7'h0, done}, 8'h00);
    check("arst_round", {3'h0, round_idx}, 8'h00);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'hF);
      check("post_arst_valid", {7'h0, out_valid}, 8'h00);
      check("post_arst_out", {4'h0, out}, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
